// File: rtl/sdram_rw_scheduler.sv
// SDRAM burst scheduler: arbitrates camera write / VGA read bursts.
// Ports: S_CLK, RST_N, FIFO levels, acks in; requests, addr, bank out.
// Optional macro PINGPONG_EN enables frame double-buffering by bank.
module sdram_rw_scheduler #(
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned WR_THRESH   = 256,
  parameter int unsigned RD_THRESH   = 256
) (
  input  logic        S_CLK,
  input  logic        RST_N,
  input  logic [8:0]  wr_fifo_usedw,
  input  logic [8:0]  rd_fifo_usedw,
  input  logic        rd_enable,
  input  logic        write_ack,
  input  logic        read_ack,
  output logic        write_en,
  output logic        read_en,
  output logic [19:0] addr,
  output logic [1:0]  bank,
  output logic        busy,
  output logic        wr_frame_done
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  typedef enum logic {SRV_WR, SRV_RD} srv_t;

  localparam logic [20:0] BL = 21'(BURST_LEN);
  localparam logic [20:0] FW = 21'(FRAME_WORDS);
  localparam logic [9:0]  WT = 10'(WR_THRESH);
  localparam logic [9:0]  RT = 10'(RD_THRESH);

  state_t      state_q, state_d;
  srv_t        last_q, last_d;
  logic        write_en_q, write_en_d;
  logic        read_en_q, read_en_d;
  logic [19:0] addr_q, addr_d;
  logic [1:0]  bank_q, bank_d;
  logic        busy_q, busy_d;
  logic        fdone_q, fdone_d;
  logic [19:0] wr_addr_q, wr_addr_d;
  logic [19:0] rd_addr_q, rd_addr_d;
  logic [1:0]  wr_bank_q, rd_bank_q;

  logic        wr_pend, rd_pend, go_wr;
  logic [20:0] wr_sum, rd_sum;
  logic        wr_wrap, rd_wrap;
  logic [19:0] wr_nxt, rd_nxt;
  logic        wr_done, rd_done;

  assign wr_pend = {1'b0, wr_fifo_usedw} >= WT;
  assign rd_pend = rd_enable &&
                   ({1'b0, rd_fifo_usedw} < RT);
  // Round-robin only matters when both are pending.
  assign go_wr   = wr_pend &&
                   (!rd_pend || last_q == SRV_RD);

  assign wr_sum  = {1'b0, wr_addr_q} + BL;
  assign rd_sum  = {1'b0, rd_addr_q} + BL;
  assign wr_wrap = wr_sum >= FW;
  assign rd_wrap = rd_sum >= FW;
  assign wr_nxt  = wr_wrap ? 20'd0 : wr_sum[19:0];
  assign rd_nxt  = rd_wrap ? 20'd0 : rd_sum[19:0];

  assign wr_done = (state_q == WR) && write_ack;
  assign rd_done = (state_q == RD) && read_ack;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    write_en_d = write_en_q;
    read_en_d  = read_en_q;
    addr_d     = addr_q;
    bank_d     = bank_q;
    busy_d     = busy_q;
    fdone_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    unique case (state_q)
      IDLE: begin
        if (go_wr) begin
          state_d    = WR;
          write_en_d = 1'b1;
          addr_d     = wr_addr_q;
          bank_d     = wr_bank_q;
          busy_d     = 1'b1;
        end else if (rd_pend) begin
          state_d   = RD;
          read_en_d = 1'b1;
          addr_d    = rd_addr_q;
          bank_d    = rd_bank_q;
          busy_d    = 1'b1;
        end
      end
      WR: begin
        if (write_ack) begin
          state_d    = IDLE;
          write_en_d = 1'b0;
          busy_d     = 1'b0;
          last_d     = SRV_WR;
          wr_addr_d  = wr_nxt;
          fdone_d    = wr_wrap;
        end
      end
      RD: begin
        if (read_ack) begin
          state_d   = IDLE;
          read_en_d = 1'b0;
          busy_d    = 1'b0;
          last_d    = SRV_RD;
          rd_addr_d = rd_nxt;
        end
      end
      default: begin
        state_d    = IDLE;
        write_en_d = 1'b0;
        read_en_d  = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      last_q     <= SRV_RD;
      write_en_q <= 1'b0;
      read_en_q  <= 1'b0;
      addr_q     <= 20'd0;
      bank_q     <= 2'd0;
      busy_q     <= 1'b0;
      fdone_q    <= 1'b0;
      wr_addr_q  <= 20'd0;
      rd_addr_q  <= 20'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      write_en_q <= write_en_d;
      read_en_q  <= read_en_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      busy_q     <= busy_d;
      fdone_q    <= fdone_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

`ifdef PINGPONG_EN
  // done_bank_q: bank holding the last fully written frame.
  // Reset 0 keeps reads on bank 0 until a write frame ends.
  logic [1:0] done_bank_q;

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_bank_q   <= 2'd0;
      rd_bank_q   <= 2'd0;
      done_bank_q <= 2'd0;
    end else begin
      if (wr_done && wr_wrap) begin
        wr_bank_q   <= {1'b0, ~wr_bank_q[0]};
        done_bank_q <= wr_bank_q;
      end
      if (rd_done && rd_wrap) begin
        rd_bank_q <= done_bank_q;
      end
    end
  end
`else
  logic unused_done;
  assign unused_done = wr_done ^ rd_done;
  assign wr_bank_q   = 2'd0;
  assign rd_bank_q   = 2'd0;
`endif

  assign write_en      = write_en_q;
  assign read_en       = read_en_q;
  assign addr          = addr_q;
  assign bank          = bank_q;
  assign busy          = busy_q;
  assign wr_frame_done = fdone_q;

endmodule

// File: tb/tb_sdram_rw_scheduler.sv
// Scoreboard bench for sdram_rw_scheduler.
// Expected requests are queued; a monitor checks each new request.
module tb_sdram_rw_scheduler;

  typedef struct packed {
    logic        wr;
    logic [19:0] addr;
    logic [1:0]  bank;
  } exp_t;

  localparam int ACK_LAT = 2;
  localparam int FBURSTS = 1200;

  logic        S_CLK;
  logic        RST_N;
  logic [8:0]  wr_fifo_usedw;
  logic [8:0]  rd_fifo_usedw;
  logic        rd_enable;
  logic        write_ack;
  logic        read_ack;
  logic        write_en;
  logic        read_en;
  logic [19:0] addr;
  logic [1:0]  bank;
  logic        busy;
  logic        wr_frame_done;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   req_count = 0;
  int   fd_count = 0;
  logic auto_ack = 1'b1;
  logic prev_req = 1'b0;
  exp_t e;

  sdram_rw_scheduler dut (
    .S_CLK         (S_CLK),
    .RST_N         (RST_N),
    .wr_fifo_usedw (wr_fifo_usedw),
    .rd_fifo_usedw (rd_fifo_usedw),
    .rd_enable     (rd_enable),
    .write_ack     (write_ack),
    .read_ack      (read_ack),
    .write_en      (write_en),
    .read_en       (read_en),
    .addr          (addr),
    .bank          (bank),
    .busy          (busy),
    .wr_frame_done (wr_frame_done)
  );

  initial begin
    S_CLK = 1'b0;
    forever #5 S_CLK = ~S_CLK;
  end

  // Burst engine model: ack ACK_LAT+1 cycles after request.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge S_CLK);
      if (auto_ack) begin
        write_ack = 1'b0;
        read_ack  = 1'b0;
        if (write_en || read_en) begin
          if (cnt == ACK_LAT) begin
            if (write_en) write_ack = 1'b1;
            else          read_ack  = 1'b1;
            cnt = 0;
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Monitor: each rising request is checked against the queue.
  initial begin
    forever begin
      @(negedge S_CLK);
      if (wr_frame_done) fd_count++;
      if ((write_en || read_en) && !prev_req) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req wr=%0b addr=%0d bank=%0d",
                   write_en, addr, bank);
        end else begin
          e = sb.pop_front();
          if (write_en !== e.wr || read_en !== !e.wr ||
              addr !== e.addr || bank !== e.bank) begin
            errors++;
            $display("FAIL req got wr=%0b rd=%0b addr=%0d bank=%0d %s",
                     write_en, read_en, addr, bank,
                     $sformatf("want wr=%0b addr=%0d bank=%0d",
                               e.wr, e.addr, e.bank));
          end
        end
        req_count++;
      end
      prev_req = write_en || read_en;
    end
  end

  task automatic chk(input string nm, input int got,
                     input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic push(input logic wr, input int a,
                      input int b);
    exp_t x;
    x.wr   = wr;
    x.addr = 20'(a);
    x.bank = 2'(b);
    sb.push_back(x);
  endtask

  task automatic tick();
    @(negedge S_CLK);
    #1;
  endtask

  task automatic run_until(input string nm, input int target);
    int n;
    int budget;
    n = 0;
    budget = (target - req_count) * 8 + 50;
    while (req_count < target && n < budget) begin
      tick();
      n++;
    end
    chk(nm, req_count, target);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy || write_en || read_en) && n < 50) begin
      tick();
      n++;
    end
    chk(nm, int'(busy | write_en | read_en), 0);
  endtask

  task automatic clear_in();
    wr_fifo_usedw = 9'd0;
    rd_fifo_usedw = 9'd300;
    rd_enable     = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  int base;
  int fd_base;
  int pp;

  initial begin
`ifdef PINGPONG_EN
    pp = 1;
`else
    pp = 0;
`endif
    write_ack = 1'b0;
    read_ack  = 1'b0;
    clear_in();
    RST_N = 1'b0;
    tick();
    chk("rst_write_en", int'(write_en), 0);
    chk("rst_read_en", int'(read_en), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_bank", int'(bank), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fdone", int'(wr_frame_done), 0);
    tick();
    RST_N = 1'b1;
    tick();

    // Write only: one-cycle latency, then address advance.
    base = req_count;
    push(1'b1, 0, 0);
    push(1'b1, 256, 0);
    wr_fifo_usedw = 9'd300;
    tick();
    chk("wr_latency", int'(write_en), 1);
    run_until("wr_only_run", base + 2);
    clear_in();
    wait_idle("wr_only_idle");

    // Stray acks with the engine model paused.
    auto_ack  = 1'b0;
    write_ack = 1'b0;
    read_ack  = 1'b0;
    base = req_count;
    push(1'b1, 512, 0);
    wr_fifo_usedw = 9'd300;
    run_until("stray_run", base + 1);
    clear_in();
    read_ack = 1'b1;
    tick();
    read_ack = 1'b0;
    tick();
    chk("stray_wr_en", int'(write_en), 1);
    chk("stray_addr", int'(addr), 512);
    chk("stray_busy", int'(busy), 1);
    write_ack = 1'b1;
    tick();
    write_ack = 1'b0;
    chk("ack_drop", int'(write_en), 0);
    chk("ack_busy", int'(busy), 0);
    write_ack = 1'b1;
    read_ack  = 1'b1;
    tick();
    write_ack = 1'b0;
    read_ack  = 1'b0;
    tick();
    base = req_count;
    push(1'b1, 768, 0);
    wr_fifo_usedw = 9'd300;
    run_until("idle_ack_run", base + 1);
    clear_in();
    write_ack = 1'b1;
    read_ack  = 1'b1;
    tick();
    write_ack = 1'b0;
    read_ack  = 1'b0;
    chk("both_ack_drop", int'(write_en), 0);
    tick();
    auto_ack = 1'b1;

    // Reads (read address untouched so far), reset at 512.
    base = req_count;
    push(1'b0, 0, 0);
    push(1'b0, 256, 0);
    push(1'b0, 512, 0);
    rd_enable     = 1'b1;
    rd_fifo_usedw = 9'd10;
    run_until("rd_run", base + 3);
    chk("pre_rst_addr", int'(addr), 512);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_rd_en", int'(read_en), 0);
    chk("mid_rst_addr", int'(addr), 0);
    chk("mid_rst_busy", int'(busy), 0);
    push(1'b0, 0, 0);
    tick();
    RST_N = 1'b1;
    base = req_count;
    run_until("post_rst_run", base + 1);
    rd_enable = 1'b0;
    wait_idle("rd_disable_idle");

    // Both pending from reset: strict alternation.
    clear_in();
    do_reset();
    base = req_count;
    push(1'b1, 0, 0);
    push(1'b0, 0, 0);
    push(1'b1, 256, 0);
    push(1'b0, 256, 0);
    wr_fifo_usedw = 9'd300;
    rd_enable     = 1'b1;
    rd_fifo_usedw = 9'd10;
    run_until("rr_run", base + 4);
    clear_in();
    wait_idle("rr_idle");

    // Threshold boundaries.
    base = req_count;
    wr_fifo_usedw = 9'd255;
    rd_enable     = 1'b1;
    rd_fifo_usedw = 9'd256;
    repeat (10) tick();
    chk("below_thresh", req_count, base);
    push(1'b1, 512, 0);
    wr_fifo_usedw = 9'd511;
    rd_enable     = 1'b0;
    run_until("wr_full_run", base + 1);
    clear_in();
    wait_idle("wr_full_idle");
    push(1'b0, 512, 0);
    rd_enable     = 1'b1;
    rd_fifo_usedw = 9'd0;
    run_until("rd_empty_run", base + 2);
    clear_in();
    wait_idle("rd_empty_idle");
    rd_fifo_usedw = 9'd0;
    repeat (10) tick();
    chk("rd_disabled", req_count, base + 2);
    clear_in();

    // Write frame wrap.
    do_reset();
    base    = req_count;
    fd_base = fd_count;
    for (int i = 0; i <= FBURSTS; i++)
      push(1'b1, (i % FBURSTS) * 256,
           pp * ((i / FBURSTS) % 2));
    wr_fifo_usedw = 9'd300;
    run_until("wrap_run", base + FBURSTS + 1);
    clear_in();
    wait_idle("wrap_idle");
    chk("wrap_fdone", fd_count - fd_base, 1);

    // Interleaved two frames each: bank handover on read wrap.
    do_reset();
    base    = req_count;
    fd_base = fd_count;
    for (int k = 0; k < 4 * FBURSTS + 2; k++) begin
      int i;
      int f;
      i = k / 2;
      f = i / FBURSTS;
      if (k % 2 == 0)
        push(1'b1, (i % FBURSTS) * 256, pp * (f % 2));
      else
        push(1'b0, (i % FBURSTS) * 256,
             (f == 0) ? 0 : pp * ((f - 1) % 2));
    end
    wr_fifo_usedw = 9'd300;
    rd_enable     = 1'b1;
    rd_fifo_usedw = 9'd10;
    run_until("pp_run", base + 4 * FBURSTS + 2);
    clear_in();
    wait_idle("pp_idle");
    chk("pp_fdone", fd_count - fd_base, 2);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
